conwaylife_run_ctrl: RTL

Run controller for the 16x16 toroidal Game of Life engine (ports `clk`, `load`, `data[255:0]`, `q[255:0]`).
- Loads a seed pattern and steps the engine a bounded number of generations.
- Freezes the engine when idle or paused by reloading `q` into it.
- Stops early on extinction, still life or a period-2 oscillator, and reports the generation count and termination cause.
- Sits between host/test logic and the engine instance.

---
 rtl/conwaylife_run_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/conwaylife_run_ctrl.sv
// conwaylife_run_ctrl
//
// Run controller for a 16x16 toroidal Game of Life engine. It loads a seed
// board into the engine, lets it advance one generation per cycle up to a
// programmable limit, and stops early when the board dies out or (optionally)
// settles into a still life or a period-2 oscillator.
//
// Build option:
//   CONWAYLIFE_OSC_DETECT_EN - when defined, keeps the last two boards and
//                              adds the still-life (status 2) and period-2
//                              (status 3) checks. When undefined, only
//                              extinction and the limit end a run.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           one-cycle run request, honoured only in IDLE
//   seed            initial board, captured with an accepted start
//   gen_limit       maximum generation count, captured with an accepted start
//   pause           level; freezes the board while running
//   life_load       to engine load (1 = engine takes life_data)
//   life_data       to engine data
//   life_q          from engine q (current board)
//   busy            controller is not idle
//   done            one-cycle pulse when a run ends
//   status          0 limit, 1 extinct, 2 still life, 3 period 2
//   gen_count       generations elapsed since the seed was loaded

module conwaylife_run_ctrl #(
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [255:0]     seed,
    input  logic [GEN_W-1:0] gen_limit,
    input  logic             pause,
    output logic             life_load,
    output logic [255:0]     life_data,
    input  logic [255:0]     life_q,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [GEN_W-1:0] gen_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [255:0]     seed_q, seed_d;
    logic [GEN_W-1:0] limit_q, limit_d;
    logic [GEN_W-1:0] gen_count_q, gen_count_d;
    logic [1:0]       status_q, status_d;
    logic             done_q, done_d;
`ifdef CONWAYLIFE_OSC_DETECT_EN
    logic [255:0]     prev1_q, prev1_d;
    logic [255:0]     prev2_q, prev2_d;
`endif

    logic       term;
    logic [1:0] term_status;
    logic       run_active;

    // Termination test on the board currently shown by the engine.
    // Priority order matters: an empty board that also matches history is
    // reported as extinct, and any pattern match wins over the limit.
    always_comb begin
        term        = 1'b0;
        term_status = 2'd0;
        if (life_q == '0) begin
            term        = 1'b1;
            term_status = 2'd1;
        end
`ifdef CONWAYLIFE_OSC_DETECT_EN
        else if ((gen_count_q != '0) && (life_q == prev1_q)) begin
            term        = 1'b1;
            term_status = 2'd2;
        end
        else if ((gen_count_q > GEN_W'(1)) && (life_q == prev2_q)) begin
            term        = 1'b1;
            term_status = 2'd3;
        end
`endif
        else if (gen_count_q == limit_q) begin
            term        = 1'b1;
            term_status = 2'd0;
        end
    end

    assign run_active = (state_q == ST_RUN) && !pause;

    // Engine drive. Whenever the engine must not advance, it is handed its
    // own output so the board stays put across the edge.
    always_comb begin
        life_load = 1'b1;
        life_data = life_q;
        if (state_q == ST_LOAD) begin
            life_data = seed_q;
        end else if (run_active && !term) begin
            life_load = 1'b0;
            life_data = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        limit_d     = limit_q;
        gen_count_d = gen_count_q;
        status_d    = status_q;
        done_d      = 1'b0;
`ifdef CONWAYLIFE_OSC_DETECT_EN
        prev1_d     = prev1_q;
        prev2_d     = prev2_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    seed_d      = seed;
                    limit_d     = gen_limit;
                    gen_count_d = '0;
                    status_d    = 2'd0;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                if (!pause) begin
                    if (term) begin
                        state_d  = ST_DONE;
                        status_d = term_status;
                        done_d   = 1'b1;
                    end else begin
                        // Cannot pass the limit: equality terminates first.
                        gen_count_d = gen_count_q + GEN_W'(1);
`ifdef CONWAYLIFE_OSC_DETECT_EN
                        prev2_d     = prev1_q;
                        prev1_d     = life_q;
`endif
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            seed_q      <= '0;
            limit_q     <= '0;
            gen_count_q <= '0;
            status_q    <= 2'd0;
            done_q      <= 1'b0;
`ifdef CONWAYLIFE_OSC_DETECT_EN
            prev1_q     <= '0;
            prev2_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            limit_q     <= limit_d;
            gen_count_q <= gen_count_d;
            status_q    <= status_d;
            done_q      <= done_d;
`ifdef CONWAYLIFE_OSC_DETECT_EN
            prev1_q     <= prev1_d;
            prev2_q     <= prev2_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign status    = status_q;
    assign gen_count = gen_count_q;

endmodule
